alu_fault_checker: RTL

- Built-in self-test sequencer for the faultable ALU. It drives operands, opcode and shift amount into the ALU under test.
- It computes the expected result internally, compares it with the ALU outputs, and classifies any mismatch by functional unit: adder, logic, shifter, compare.
- It sits between the fault-injection controls and the detection/reporting logic.

---
 rtl/alu_fault_checker.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_fault_checker.sv
// ---------------------------------------------------------------------------
// alu_fault_checker
//
// Built-in self-test sequencer for a faultable 32-bit ALU. It walks a Galois
// LFSR through NUM_VECTORS operand vectors and applies the six opcodes (add,
// sub, and, or, sll, sra) to each vector. Every opcode takes two cycles:
//   - APPLY: the operands are presented to the ALU.
//   - CHECK: the returned result and flags are compared with an internally
//     computed golden value.
// Mismatches are classified by functional unit into sticky fault flags and
// counted in a saturating counter.
//
// Ports
//   clock, reset     : clock and synchronous active-high reset
//   start            : launches a run when sampled high in IDLE or DONE
//   data_operandA/B  : operands driven to the ALU under test (registered)
//   ctrl_ALUopcode   : 0 add, 1 sub, 2 and, 3 or, 4 sll, 5 sra (registered)
//   ctrl_shiftamt    : shift amount, bit 4 always 0 (registered)
//   dut_result       : result returned by the ALU under test
//   dut_isNotEqual   : isNotEqual flag returned by the ALU under test
//   dut_isLessThan   : isLessThan flag returned by the ALU under test
//   busy, done       : run in progress / run finished
//   fault_*          : sticky per-unit mismatch flags
//   fail_count       : saturating count of mismatching checks
//   first_fail_vec   : vector index of the first mismatch of the run
//   first_fail_op    : opcode of the first mismatch of the run
// ---------------------------------------------------------------------------
module alu_fault_checker #(
    parameter int          NUM_VECTORS = 64,
    parameter logic [31:0] SEED        = 32'hACE1_1234,
    parameter int          CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    output logic [31:0]      data_operandA,
    output logic [31:0]      data_operandB,
    output logic [4:0]       ctrl_ALUopcode,
    output logic [4:0]       ctrl_shiftamt,
    input  logic [31:0]      dut_result,
    input  logic             dut_isNotEqual,
    input  logic             dut_isLessThan,
    output logic             busy,
    output logic             done,
    output logic             fault_add,
    output logic             fault_logic,
    output logic             fault_shift,
    output logic             fault_cmp,
    output logic [CNT_W-1:0] fail_count,
    output logic [15:0]      first_fail_vec,
    output logic [2:0]       first_fail_op
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Galois taps for x^32 + x^22 + x^2 + x + 1, right-shifting form.
    localparam logic [31:0]      LFSR_MASK = 32'h8020_0003;
    localparam logic [15:0]      LAST_VEC  = 16'(NUM_VECTORS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);

    // One LFSR step.
    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        logic [31:0] n;
        n = {1'b0, l[31:1]};
        if (l[0]) begin
            n = n ^ LFSR_MASK;
        end else begin
            n = n;
        end
        return n;
    endfunction

    // Operand B is operand A with its 16-bit halves exchanged.
    function automatic logic [31:0] swap_halves(input logic [31:0] l);
        return {l[15:0], l[31:16]};
    endfunction

    // Reference result for each opcode; shifts use a 4-bit amount.
    function automatic logic [31:0] golden_result(input logic [31:0] a,
                                                  input logic [31:0] b,
                                                  input logic [2:0]  op,
                                                  input logic [3:0]  sh);
        logic [31:0] r;
        case (op)
            3'd0:    r = a + b;
            3'd1:    r = a + ~b + 32'd1;
            3'd2:    r = a & b;
            3'd3:    r = a | b;
            3'd4:    r = a << sh;
            3'd5:    r = $signed(a) >>> sh;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    state_t             state_r;
    logic [31:0]        lfsr_r;
    logic [31:0]        opa_r;
    logic [31:0]        opb_r;
    logic [3:0]         sh_r;
    logic [2:0]         op_r;
    logic [15:0]        vec_r;
    logic               busy_r;
    logic               done_r;
    logic               f_add_r;
    logic               f_logic_r;
    logic               f_shift_r;
    logic               f_cmp_r;
    logic [CNT_W-1:0]   fail_cnt_r;
    logic [15:0]        ff_vec_r;
    logic [2:0]         ff_op_r;

    logic [31:0]        gold_res_s;
    logic               gold_ne_s;
    logic               gold_lt_s;
    logic               res_mis_s;
    logic               cmp_mis_s;
    logic               any_mis_s;
    logic [31:0]        lfsr_adv_s;

    // Golden values and mismatch detection for the vector currently applied.
    always_comb begin
        gold_res_s = golden_result(opa_r, opb_r, op_r, sh_r);
        gold_ne_s  = ((opa_r - opb_r) != 32'd0);
        gold_lt_s  = ($signed(opa_r) < $signed(opb_r));
        res_mis_s  = (dut_result != gold_res_s);
        if (op_r == 3'd1) begin
            cmp_mis_s = (dut_isNotEqual != gold_ne_s) || (dut_isLessThan != gold_lt_s);
        end else begin
            cmp_mis_s = 1'b0;
        end
        any_mis_s  = res_mis_s | cmp_mis_s;
        lfsr_adv_s = lfsr_step(lfsr_r);
    end

    // Sequencer, operand registers and result bookkeeping.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            lfsr_r     <= SEED;
            opa_r      <= 32'd0;
            opb_r      <= 32'd0;
            sh_r       <= 4'd0;
            op_r       <= 3'd0;
            vec_r      <= 16'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            f_add_r    <= 1'b0;
            f_logic_r  <= 1'b0;
            f_shift_r  <= 1'b0;
            f_cmp_r    <= 1'b0;
            fail_cnt_r <= CNT_ZERO;
            ff_vec_r   <= 16'd0;
            ff_op_r    <= 3'd0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        // Every run restarts from SEED, so reruns repeat the same vectors.
                        state_r    <= ST_APPLY;
                        lfsr_r     <= SEED;
                        opa_r      <= SEED;
                        opb_r      <= swap_halves(SEED);
                        sh_r       <= SEED[3:0];
                        op_r       <= 3'd0;
                        vec_r      <= 16'd0;
                        busy_r     <= 1'b1;
                        done_r     <= 1'b0;
                        f_add_r    <= 1'b0;
                        f_logic_r  <= 1'b0;
                        f_shift_r  <= 1'b0;
                        f_cmp_r    <= 1'b0;
                        fail_cnt_r <= CNT_ZERO;
                        ff_vec_r   <= 16'd0;
                        ff_op_r    <= 3'd0;
                    end else begin
                        state_r <= state_r;
                    end
                end

                ST_APPLY: begin
                    state_r <= ST_CHECK;
                end

                ST_CHECK: begin
                    if (any_mis_s) begin
                        case (op_r)
                            3'd0, 3'd1: f_add_r   <= f_add_r   | res_mis_s;
                            3'd2, 3'd3: f_logic_r <= f_logic_r | res_mis_s;
                            3'd4, 3'd5: f_shift_r <= f_shift_r | res_mis_s;
                            default:    f_add_r   <= f_add_r;
                        endcase
                        f_cmp_r <= f_cmp_r | cmp_mis_s;
                        // The counter saturates and never wraps, so zero means no failure yet.
                        if (fail_cnt_r == CNT_ZERO) begin
                            ff_vec_r <= vec_r;
                            ff_op_r  <= op_r;
                        end else begin
                            ff_vec_r <= ff_vec_r;
                        end
                        if (fail_cnt_r != CNT_MAX) begin
                            fail_cnt_r <= fail_cnt_r + CNT_ONE;
                        end else begin
                            fail_cnt_r <= fail_cnt_r;
                        end
                    end else begin
                        fail_cnt_r <= fail_cnt_r;
                    end

                    if (op_r < 3'd5) begin
                        op_r    <= op_r + 3'd1;
                        state_r <= ST_APPLY;
                    end else if (vec_r < LAST_VEC) begin
                        op_r    <= 3'd0;
                        vec_r   <= vec_r + 16'd1;
                        lfsr_r  <= lfsr_adv_s;
                        opa_r   <= lfsr_adv_s;
                        opb_r   <= swap_halves(lfsr_adv_s);
                        sh_r    <= lfsr_adv_s[3:0];
                        state_r <= ST_APPLY;
                    end else begin
                        // Operands keep the last vector while DONE.
                        state_r <= ST_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end
                end

                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign data_operandA  = opa_r;
    assign data_operandB  = opb_r;
    assign ctrl_ALUopcode = {2'b00, op_r};
    assign ctrl_shiftamt  = {1'b0, sh_r};
    assign busy           = busy_r;
    assign done           = done_r;
    assign fault_add      = f_add_r;
    assign fault_logic    = f_logic_r;
    assign fault_shift    = f_shift_r;
    assign fault_cmp      = f_cmp_r;
    assign fail_count     = fail_cnt_r;
    assign first_fail_vec = ff_vec_r;
    assign first_fail_op  = ff_op_r;

endmodule
